clock_set_ctrl: RTL and testbench

Parametrised set/advance controller for the configurable digital clock. It conditions NUM_FIELDS active-low push-buttons with synchronisation, debounce, press-edge detection and optional hold-to-auto-repeat. Each resulting pulse is merged with the ripple carry of the matching time field to produce that field's count enable. It sits between the board buttons and the seconds/minutes/hours counter chain, replacing the fixed two-button controller.

---
 rtl/clock_ctrl_pkg.sv | 25 ++
 rtl/btn_conditioner.sv | 129 ++++++++++++
 rtl/clock_set_ctrl.sv | 64 ++++++
 tb/tb_clock_set_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared types and constants for the clock set/advance controller.
//   btn_state_e          per-button conditioner FSM state
//   *_DEF                default cycle counts for a 50 MHz clk
//   cnt_width()          bits needed for a counter holding 0 .. n-1
// ----------------------------------------------------------------------------
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      BTN_IDLE   = 2'd0,
      BTN_DELAY  = 2'd1,
      BTN_REPEAT = 2'd2
   } btn_state_e;

   // 10 ms debounce, 500 ms before auto-repeat, then 100 ms between repeats
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
   localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// ----------------------------------------------------------------------------
// btn_conditioner
// One active-low push-button: 2-FF synchroniser, debounce, press-edge
// detection and (optionally) hold-to-auto-repeat.
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_n        asynchronous button, active low
//   press_pulse  one-cycle pulse per accepted press / repeat
// Build option: CLOCK_AUTO_REPEAT_EN compiles in BTN_DELAY/BTN_REPEAT and the
// repeat timer; without it the FSM is idle/held, one pulse per press.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   BTN_IDLE   | accepted level released, waiting for an accepted press
//   BTN_DELAY  | pressed, timer counting REPEAT_DELAY (held state when
//              | auto-repeat is not built)
//   BTN_REPEAT | pressed, pulse every REPEAT_PERIOD cycles
// ----------------------------------------------------------------------------
module btn_conditioner
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press_pulse
);

   localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_chk
      $error("btn_conditioner: cycle counts must be >= 2");
   end

   logic            sync_q1;
   logic            sync_q2;
   logic            level_q;   // accepted level, 1 = released
   logic [DB_W-1:0] db_cnt;
   logic            pressed;
   btn_state_e      state;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
         level_q <= 1'b1;
         db_cnt  <= '0;
      end else begin
         sync_q1 <= btn_n;
         sync_q2 <= sync_q1;
         if (sync_q2 == level_q) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= sync_q2;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign pressed = ~level_q;

`ifdef CLOCK_AUTO_REPEAT_EN
   localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

   // Down-counter loaded with N-1; the pulse fires on the cycle it is seen at 0,
   // so successive pulses are exactly N cycles apart.
   logic [TMR_W-1:0] tmr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BTN_IDLE;
         tmr         <= '0;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            BTN_IDLE: begin
               if (pressed) begin
                  press_pulse <= 1'b1;
                  tmr         <= TMR_W'(REPEAT_DELAY - 1);
                  state       <= BTN_DELAY;
               end
            end
            BTN_DELAY, BTN_REPEAT: begin
               // release wins over a coincident timer expiry
               if (!pressed) begin
                  state <= BTN_IDLE;
               end else if (tmr == '0) begin
                  press_pulse <= 1'b1;
                  tmr         <= TMR_W'(REPEAT_PERIOD - 1);
                  state       <= BTN_REPEAT;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: state <= BTN_IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BTN_IDLE;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            BTN_IDLE: begin
               if (pressed) begin
                  press_pulse <= 1'b1;
                  state       <= BTN_DELAY;
               end
            end
            BTN_DELAY: begin
               if (!pressed) state <= BTN_IDLE;
            end
            default: state <= BTN_IDLE;
         endcase
      end
   end
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// ----------------------------------------------------------------------------
// clock_set_ctrl
// Set/advance controller for the digital clock. Conditions NUM_FIELDS buttons
// and merges each press pulse with the ripple carry of its time field.
//   clk         system clock
//   rst         synchronous active-high reset
//   set_n       asynchronous set-mode switch, active low
//   btn_n       asynchronous field buttons, active low (bit i -> field i)
//   carry_in    ripple carry into field i (bit 0 = 1 Hz tick)
//   enable_out  count enable for field i (combinational from carry_in)
//   set_active  synchronised set mode, used to freeze the seconds tick
// Build option: CLOCK_AUTO_REPEAT_EN enables hold-to-auto-repeat.
// ----------------------------------------------------------------------------
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned NUM_FIELDS      = 3,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_n,
   input  logic [NUM_FIELDS-1:0] btn_n,
   input  logic [NUM_FIELDS-1:0] carry_in,
   output logic [NUM_FIELDS-1:0] enable_out,
   output logic                  set_active
);

   logic                  set_q1;
   logic                  set_q2;
   logic [NUM_FIELDS-1:0] press_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         set_q1     <= 1'b1;
         set_q2     <= 1'b1;
         set_active <= 1'b0;
      end else begin
         set_q1     <= set_n;
         set_q2     <= set_q1;
         set_active <= ~set_q2;
      end
   end

   for (genvar i = 0; i < int'(NUM_FIELDS); i++) begin : g_field
      btn_conditioner #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_cond (
         .clk         (clk),
         .rst         (rst),
         .btn_n       (btn_n[i]),
         .press_pulse (press_pulse[i])
      );
   end

   // Pulses outside set mode are dropped; a pulse coincident with carry gives
   // a single enable (one increment lost, seconds are frozen while setting).
   assign enable_out = carry_in | (press_pulse & {NUM_FIELDS{set_active}});

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       set_n;
   logic [2:0] btn_n;
   logic [2:0] carry_in;
   logic [2:0] enable_out;
   logic       set_active;

   always #5 clk = ~clk;

   clock_set_ctrl #(
      .NUM_FIELDS      (3),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .set_n      (set_n),
      .btn_n      (btn_n),
      .carry_in   (carry_in),
      .enable_out (enable_out),
      .set_active (set_active)
   );

   typedef struct {
      int         cyc;
      logic [2:0] en;
      bit         chk_set;
      logic       set;
   } exp_t;

   exp_t       expq[$];
   exp_t       mon_e;
   logic [2:0] sched [int];
   int         cyc_n  = 0;
   int         checks = 0;
   int         errors = 0;

   logic       r_v;
   logic       sn_v;
   logic [2:0] bn_v;
   int         mode;

   function automatic logic [2:0] carry_pat(input int n, input int m);
      case (m)
         1:       return 3'b010;
         2:       return ((n % 4) == 0) ? 3'b010 : 3'b000;
         3:       return ((n % 5) == 0) ? 3'b001 : 3'b000;
         default: return 3'b000;
      endcase
   endfunction

   task automatic add_pulse(input int cyc, input logic [2:0] m);
      if (sched.exists(cyc)) sched[cyc] = sched[cyc] | m;
      else                   sched[cyc] = m;
   endtask

   // Drive inputs for the next cycle and queue what the DUT must show in it.
   task automatic tick(input bit cs = 1'b0, input logic es = 1'b0);
      exp_t       e;
      logic [2:0] car;
      logic [2:0] p;
      @(posedge clk);
      #1;
      cyc_n++;
      car      = carry_pat(cyc_n, mode);
      rst      = r_v;
      set_n    = sn_v;
      btn_n    = bn_v;
      carry_in = car;
      p        = sched.exists(cyc_n) ? sched[cyc_n] : 3'b000;
      e.cyc     = cyc_n;
      e.en      = car | p;
      e.chk_set = cs;
      e.set     = es;
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   always @(negedge clk) begin
      if (expq.size() != 0) begin
         mon_e = expq.pop_front();
         checks++;
         if (enable_out !== mon_e.en) begin
            errors++;
            $display("FAIL enable_out cycle %0d: actual=%b required=%b", mon_e.cyc, enable_out, mon_e.en);
         end
         if (mon_e.chk_set) begin
            checks++;
            if (set_active !== mon_e.set) begin
               errors++;
               $display("FAIL set_active cycle %0d: actual=%b required=%b", mon_e.cyc, set_active, mon_e.set);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c;
      int guard;
      r_v = 1'b1; sn_v = 1'b1; bn_v = 3'b111; mode = 1;
      rst = 1'b1; set_n = 1'b1; btn_n = 3'b111; carry_in = 3'b010;

      // 1: reset, then idle with carry passing straight through
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      r_v = 1'b0;
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
      mode = 3;
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);

      // 2: set mode, single press held 5 cycles
      c = cyc_n + 1;
      sn_v = 1'b0;
      tick(1'b1, 1'b0);   // c
      tick(1'b1, 1'b0);   // c+1
      tick(1'b1, 1'b0);   // c+2
      tick();             // c+3
      tick(1'b1, 1'b1);   // c+4
      idle(4);
      mode = 0;
      c = cyc_n + 1;
      add_pulse(c + 3 + DB, 3'b010);
      bn_v = 3'b101;
      idle(5);
      bn_v = 3'b111;
      idle(15);

      // 3: bounce on field 2 shorter than the debounce window
      mode = 3;
      for (int i = 0; i < 20; i++) begin
         bn_v = (((i / 2) % 2) == 0) ? 3'b011 : 3'b111;
         tick();
      end
      bn_v = 3'b111;
      idle(12);

      // 4: field 2 held 25 cycles in set mode
      mode = 0;
      c = cyc_n + 1;
      add_pulse(c + 7, 3'b100);
`ifdef CLOCK_AUTO_REPEAT_EN
      add_pulse(c + 17, 3'b100);
      add_pulse(c + 20, 3'b100);
      add_pulse(c + 23, 3'b100);
      add_pulse(c + 26, 3'b100);
      add_pulse(c + 29, 3'b100);
`endif
      bn_v = 3'b011;
      idle(25);
      bn_v = 3'b111;
      idle(15);

      // 5: hold outside set mode, then enter set mode mid-hold
      mode = 2;
      sn_v = 1'b1;
      idle(6);
      tick(1'b1, 1'b0);
      c = cyc_n + 1;
`ifdef CLOCK_AUTO_REPEAT_EN
      add_pulse(c + 23, 3'b010);
      add_pulse(c + 26, 3'b010);
      add_pulse(c + 29, 3'b010);
      add_pulse(c + 32, 3'b010);
`endif
      bn_v = 3'b101;
      for (int i = 0; i < 28; i++) begin
         if (i == 18) sn_v = 1'b0;
         if (i == 26) tick(1'b1, 1'b1);
         else         tick();
      end
      bn_v = 3'b111;
      idle(12);

      // 6: simultaneous presses on fields 0 and 2, reset mid-hold
      mode = 3;
      c = cyc_n + 1;
      add_pulse(c + 7, 3'b101);
      add_pulse(c + 21, 3'b101);
      bn_v = 3'b010;
      for (int i = 0; i < 23; i++) begin
         r_v = (i == 12 || i == 13);
         if (i == 13 || i == 14) tick(1'b1, 1'b0);
         else if (i == 19)       tick(1'b1, 1'b1);
         else                    tick();
      end
      r_v  = 1'b0;
      bn_v = 3'b111;
      idle(15);

      guard = 0;
      while (expq.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: actual=%0d pending required=0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
